axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Parametrised N-master to 1-slave AXI4 read-channel arbiter; replaces the fixed two-source (fetch/load) read muxing in the interconnect.
- Sits between the per-unit read interfaces (fetch, load, future DMA/PTW) and the single external read port.
- Round-robin grant, one outstanding burst at a time, burst-locked until the final R beat.
- Tracks beats against ARLEN and flags protocol violations.

Parameters:
NUM_M, 2, number of masters (2..8)
ID_W, 4, AXI ID width
ADDR_W, 32, address width
DATA_W, 64, data width
AR_W, ID_W+ADDR_W+8+3+2, packed AR payload width {id,addr,len,size,burst}
R_W, ID_W+DATA_W+2+1, packed R payload width {id,data,resp,last}

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m_arvalid  in  NUM_M  per-master ARVALID
m_arready  out  NUM_M  per-master ARREADY
m_ar  in  NUM_M*AR_W  per-master packed AR payload; master i at [i*AR_W +: AR_W]
m_rvalid  out  NUM_M  per-master RVALID
m_rready  in  NUM_M  per-master RREADY
m_r  out  R_W  R payload broadcast to all masters; qualified by m_rvalid
s_arvalid  out  1  slave ARVALID
s_arready  in  1  slave ARREADY
s_ar  out  AR_W  slave AR payload
s_rvalid  in  1  slave RVALID
s_rready  out  1  slave RREADY
s_r  in  R_W  slave R payload
busy  out  1  burst in flight (ADDR or DATA state)
err_beat  out  1  sticky: RLAST/beat-count mismatch seen

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - FSM = IDLE, grant = 0, rr_ptr = 0, beat_cnt = 0, len_q = 0.
  - All outputs 0: s_arvalid, m_arready, m_rvalid, s_rready, busy, err_beat; s_ar and m_r are 0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any m_arvalid is set, pick the first requester at or after rr_ptr (circular index) and register its index in grant; next state ADDR.
  - Otherwise stay in IDLE.
  - Nothing is forwarded in IDLE, so arbitration costs 1 cycle.
- ADDR:
  - s_arvalid = m_arvalid[grant], s_ar = m_ar[grant], m_arready[grant] = s_arready; all other m_arready are 0.
  - On s_arvalid && s_arready: latch len_q = ARLEN, clear beat_cnt, next state DATA.
  - If the granted master drops arvalid (illegal), stay in ADDR. No re-arbitration.
- DATA:
  - m_rvalid[grant] = s_rvalid, s_rready = m_rready[grant], m_r = s_r; all other m_rvalid are 0.
  - Each R handshake increments beat_cnt (9-bit, no wrap for len ≤ 255).
  - Handshake with RLAST=1:
    - next state IDLE, rr_ptr = grant+1 mod NUM_M;
    - set err_beat if beat_cnt != len_q.
  - Handshake with RLAST=0 and beat_cnt == len_q: set err_beat, stay in DATA until RLAST.
- Routing uses the stored grant only. IDs pass through unmodified.
- Simultaneous requests: exactly one grant. Requests from the other masters wait with arready=0 and must hold their payload stable.
- Back-to-back: a new grant is possible in the cycle after the last beat. Minimum 3 cycles per single-beat transaction with a zero-wait slave.
- Reset mid-burst: everything returns to its reset value immediately; the slave-side burst is abandoned (system reset covers the slave).
- busy = (state != IDLE).
- err_beat clears only on reset.

Optional Feature:
- Macro: AXI_RD_ARB_PRIO0_EN.
- Defined: master 0 wins in IDLE whenever m_arvalid[0]=1, regardless of rr_ptr. Other masters arbitrate round-robin among themselves; rr_ptr does not advance after master 0's bursts. Intended for fetch priority.
- Undefined: pure round-robin over all NUM_M masters.

Test Plan:
1. NUM_M=2; only m0 requests addr 0x8000_0000, len 0, zero-wait slave → s_arvalid in cycle 2 after request; one R beat returned to m0 only; busy high 2 cycles; rr_ptr=1.
2. m0 and m1 request in the same cycle, repeated 4 times (default build) → grants alternate m0, m1, m0, m1; m_arready never set for the non-granted master.
3. NUM_M=4; m2 burst len=3 with slave RVALID gaps and m2 RREADY low for 2 cycles → exactly 4 beats reach m2 with data unchanged; no beat lost or duplicated; err_beat=0.
4. Slave asserts RLAST on beat 2 of a len=3 burst → err_beat=1 after that handshake; FSM returns to IDLE; next request still granted.
5. rst_n pulled low in DATA mid-burst → all outputs 0 without waiting for a clk edge; after release, a fresh m1 request is granted from rr_ptr=0.
6. AXI_RD_ARB_PRIO0_EN defined; m0 requests continuously, m1 and m2 alternate → every IDLE grant goes to m0 while it requests; once m0 stops, m1 and m2 alternate.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Purpose : N-master to 1-slave AXI4 read-channel arbiter, round-robin, one burst in flight, burst-locked to RLAST.
// Latency : 1 cycle arbitration in IDLE, then AR and R are forwarded combinationally on the stored grant.
// Backpres: non-granted masters see arready=0; R backpressure passes straight through from the granted master.
// Optional: define AXI_RD_ARB_PRIO0_EN to give master 0 absolute priority at arbitration time.
module axi_rd_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int AR_W   = ID_W + ADDR_W + 8 + 3 + 2,
    parameter int R_W    = ID_W + DATA_W + 2 + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_M-1:0]      m_arvalid,
    output logic [NUM_M-1:0]      m_arready,
    input  logic [NUM_M*AR_W-1:0] m_ar,
    output logic [NUM_M-1:0]      m_rvalid,
    input  logic [NUM_M-1:0]      m_rready,
    output logic [R_W-1:0]        m_r,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic [AR_W-1:0]       s_ar,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [R_W-1:0]        s_r,
    output logic                  busy,
    output logic                  err_beat
);

    localparam int IDX_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    // ARLEN sits just above {size[2:0], burst[1:0]} in the packed AR payload
    localparam int LEN_LSB = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [8:0]       r_beat_cnt;
    logic [7:0]       r_len_q;
    logic             r_err_beat;
    logic             r_busy;

    logic             w_pick_vld;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_rr_next;
    logic             w_ar_hs;
    logic             w_r_hs;
    logic             w_r_last;
    logic             w_cnt_at_len;
    logic [AR_W-1:0]  w_ar_arr [NUM_M];

    // Split the flat AR bus into one entry per master so the mux indexes by grant
    for (genvar g = 0; g < NUM_M; g++) begin : g_ar_split
        assign w_ar_arr[g] = m_ar[g*AR_W +: AR_W];
    end

    // Round-robin pick: first requester at or after rr_ptr; the descending loop lets the nearest one win
    always_comb begin
        logic [IDX_W:0] v_sum;
        v_sum      = '0;
        w_pick_vld = 1'b0;
        w_pick     = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            v_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (v_sum >= (IDX_W+1)'(NUM_M)) begin
                v_sum = v_sum - (IDX_W+1)'(NUM_M);
            end
            if (m_arvalid[v_sum[IDX_W-1:0]]) begin
                w_pick_vld = 1'b1;
                w_pick     = v_sum[IDX_W-1:0];
            end
        end
`ifdef AXI_RD_ARB_PRIO0_EN
        // Fetch on master 0 pre-empts the rotation whenever it is asking
        if (m_arvalid[0]) begin
            w_pick_vld = 1'b1;
            w_pick     = '0;
        end
`endif
    end

    assign w_rr_next    = (r_grant == IDX_W'(NUM_M - 1)) ? '0 : r_grant + IDX_W'(1);
    assign w_ar_hs      = s_arvalid && s_arready;
    assign w_r_hs       = s_rvalid && s_rready;
    assign w_r_last     = s_r[0];
    assign w_cnt_at_len = (r_beat_cnt == {1'b0, r_len_q});

    // Channel routing: only the stored grant is connected, everything is zero in IDLE
    always_comb begin
        s_arvalid = 1'b0;
        s_ar      = '0;
        m_arready = '0;
        m_rvalid  = '0;
        s_rready  = 1'b0;
        m_r       = '0;
        case (r_state)
            ST_ADDR: begin
                s_arvalid          = m_arvalid[r_grant];
                s_ar               = w_ar_arr[r_grant];
                m_arready[r_grant] = s_arready;
            end
            ST_DATA: begin
                m_rvalid[r_grant] = s_rvalid;
                s_rready          = m_rready[r_grant];
                m_r               = s_r;
            end
            default: begin
            end
        endcase
    end

    // Arbitration FSM with beat tracking and sticky beat-count error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_len_q    <= '0;
            r_err_beat <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_grant <= w_pick;
                        r_state <= ST_ADDR;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    // A master dropping arvalid here just stalls; the grant is held
                    if (w_ar_hs) begin
                        r_len_q    <= s_ar[LEN_LSB +: 8];
                        r_beat_cnt <= '0;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_r_hs) begin
                        r_beat_cnt <= r_beat_cnt + 9'd1;
                        if (w_r_last) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
`ifdef AXI_RD_ARB_PRIO0_EN
                            // Master 0 bursts do not move the rotation for the others
                            if (r_grant != '0) begin
                                r_rr_ptr <= w_rr_next;
                            end
`else
                            r_rr_ptr <= w_rr_next;
`endif
                            if (!w_cnt_at_len) begin
                                r_err_beat <= 1'b1;
                            end
                        end else if (w_cnt_at_len) begin
                            // Expected RLAST on this beat; keep draining until the slave ends it
                            r_err_beat <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign err_beat = r_err_beat;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
`timescale 1ns/1ps
module tb_axi_rd_arbiter;

    localparam int NUM_M  = 4;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int AR_W   = ID_W + ADDR_W + 8 + 3 + 2;
    localparam int R_W    = ID_W + DATA_W + 2 + 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_M-1:0]      m_arvalid;
    logic [NUM_M-1:0]      m_arready;
    logic [NUM_M*AR_W-1:0] m_ar;
    logic [NUM_M-1:0]      m_rvalid;
    logic [NUM_M-1:0]      m_rready;
    logic [R_W-1:0]        m_r;
    logic                  s_arvalid;
    logic                  s_arready;
    logic [AR_W-1:0]       s_ar;
    logic                  s_rvalid;
    logic                  s_rready;
    logic [R_W-1:0]        s_r;
    logic                  busy;
    logic                  err_beat;

    axi_rd_arbiter #(
        .NUM_M(NUM_M), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AR_W(AR_W), .R_W(R_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_ar(m_ar),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_r(m_r),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar(s_ar),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r(s_r),
        .busy(busy), .err_beat(err_beat)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NUM_M-1:0] oh(input logic [1:0] m);
        logic [NUM_M-1:0] v;
        v    = '0;
        v[m] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] mk_addr(input int m, input int seq);
        return 32'h8000_0000 + 32'(m) * 32'h1000 + 32'(seq) * 32'h40;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed { logic [1:0] m; logic [31:0] addr; logic [7:0] len; } ar_exp_t;
    typedef struct packed { logic [1:0] m; logic [63:0] data; logic last; } r_exp_t;
    ar_exp_t ar_q[$];
    r_exp_t  r_q[$];
    int      exp_seq[NUM_M];

    task automatic expect_burst(input int m, input int len, input int nb);
        ar_exp_t a;
        r_exp_t  r;
        a.m    = 2'(m);
        a.addr = mk_addr(m, exp_seq[m]);
        a.len  = 8'(len);
        exp_seq[m]++;
        ar_q.push_back(a);
        for (int b = 0; b < nb; b++) begin
            r.m    = 2'(m);
            r.data = {a.addr, 32'(b)};
            r.last = (b == nb - 1);
            r_q.push_back(r);
        end
    endtask

    // ---------------- master driver ----------------
    int         drv_seq[NUM_M];
    int         req_left[NUM_M];
    logic [7:0] len_cfg[NUM_M];

    task automatic load_ar(input int i);
        m_ar[i*AR_W +: AR_W] = {4'(i), mk_addr(i, drv_seq[i]), len_cfg[i], 3'd3, 2'b01};
        drv_seq[i]++;
        m_arvalid[i] = 1'b1;
    endtask

    task automatic issue(input int m, input int n, input int len);
        len_cfg[m]  = 8'(len);
        req_left[m] = n - 1;
        load_ar(m);
    endtask

    initial begin
        logic [NUM_M-1:0] hs;
        forever begin
            @(negedge clk);
            hs = m_arvalid & m_arready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_M; i++) begin
                if (hs[i]) begin
                    if (req_left[i] > 0) begin
                        req_left[i]--;
                        load_ar(i);
                    end else begin
                        m_arvalid[i] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- slave model ----------------
    typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] last_idx; } sb_t;
    sb_t sq[$];
    int  s_beat = 0;
    int  slv_early = -1;
    bit  slv_gap = 1'b0;

    initial begin
        logic            ar_hs;
        logic            r_hs;
        logic [AR_W-1:0] cap;
        sb_t             sb;
        s_arready = 1'b1;
        s_rvalid  = 1'b0;
        s_r       = '0;
        forever begin
            @(negedge clk);
            ar_hs = s_arvalid && s_arready;
            r_hs  = s_rvalid && s_rready;
            cap   = s_ar;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                sq.delete();
                s_beat   = 0;
                s_rvalid = 1'b0;
                s_r      = '0;
            end else begin
                if (ar_hs) begin
                    sb.id       = cap[AR_W-1 -: ID_W];
                    sb.addr     = cap[AR_W-ID_W-1 -: ADDR_W];
                    sb.last_idx = (slv_early >= 0) ? 8'(slv_early) : cap[12:5];
                    slv_early   = -1;
                    sq.push_back(sb);
                end
                if (r_hs && sq.size() > 0) begin
                    if (s_beat == int'(sq[0].last_idx)) begin
                        void'(sq.pop_front());
                        s_beat = 0;
                    end else begin
                        s_beat++;
                    end
                end
                if (s_rvalid && !r_hs) begin
                    // hold the beat until it is taken
                end else if (sq.size() > 0 && (!slv_gap || $urandom_range(0, 2) != 0)) begin
                    s_rvalid = 1'b1;
                    s_r = {sq[0].id, sq[0].addr, 32'(s_beat), 2'b00, (s_beat == int'(sq[0].last_idx))};
                end else begin
                    s_rvalid = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        ar_exp_t a;
        r_exp_t  r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m_arready != '0) begin
                    if (ar_q.size() == 0) chk("arready_unexp", m_arready, 0);
                    else                  chk("arready_grant", m_arready, oh(ar_q[0].m));
                end
                if (s_arvalid && s_arready) begin
                    if (ar_q.size() == 0) begin
                        chk("ar_unexp", s_ar, 0);
                    end else begin
                        a = ar_q.pop_front();
                        chk("ar_id",   s_ar[AR_W-1 -: ID_W], a.m);
                        chk("ar_addr", s_ar[AR_W-ID_W-1 -: ADDR_W], a.addr);
                        chk("ar_len",  s_ar[12:5], a.len);
                    end
                end
                if (m_rvalid != '0) begin
                    if (r_q.size() == 0) begin
                        chk("rvalid_unexp", m_rvalid, 0);
                    end else begin
                        chk("rvalid_grant", m_rvalid, oh(r_q[0].m));
                        if ((m_rvalid & m_rready) != '0) begin
                            r = r_q.pop_front();
                            chk("r_data", m_r[R_W-ID_W-1 -: DATA_W], r.data);
                            chk("r_id",   m_r[R_W-1 -: ID_W], r.m);
                            chk("r_last", m_r[0], r.last);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy || ar_q.size() != 0 || r_q.size() != 0 || m_arvalid != '0) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= budget) chk(tag, {busy, m_arvalid, 8'(ar_q.size()), 8'(r_q.size())}, 0);
    endtask

    task automatic wait_rq(input string tag, input int lvl, input int budget);
        int n;
        n = 0;
        while (r_q.size() > lvl && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= budget) chk(tag, r_q.size(), lvl);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        m_arvalid = '0;
        m_ar      = '0;
        m_rready  = '1;
        for (int i = 0; i < NUM_M; i++) begin
            drv_seq[i] = 0; exp_seq[i] = 0; req_left[i] = 0; len_cfg[i] = '0;
        end
        #1;
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_m_arready", m_arready, 0);
        chk("rst_m_rvalid",  m_rvalid, 0);
        chk("rst_s_rready",  s_rready, 0);
        chk("rst_busy",      busy, 0);
        chk("rst_err",       err_beat, 0);
        chk("rst_s_ar",      s_ar, 0);
        chk("rst_m_r",       m_r, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #2;

        // single beat from m0, arbitration cycle then ADDR then DATA
        expect_burst(0, 0, 1);
        issue(0, 1, 0);
        @(negedge clk);
        chk("t1_c0_arvalid", s_arvalid, 0);
        chk("t1_c0_busy", busy, 0);
        @(negedge clk);
        chk("t1_c1_arvalid", s_arvalid, 1);
        chk("t1_c1_busy", busy, 1);
        @(negedge clk);
        chk("t1_c2_arvalid", s_arvalid, 0);
        chk("t1_c2_busy", busy, 1);
        chk("t1_c2_rvalid", m_rvalid, 4'b0001);
        @(negedge clk);
        chk("t1_c3_busy", busy, 0);
        wait_done("t1_timeout", 50);

        // m0 and m1 together, two each
`ifdef AXI_RD_ARB_PRIO0_EN
        expect_burst(0, 0, 1); expect_burst(0, 0, 1);
        expect_burst(1, 0, 1); expect_burst(1, 0, 1);
`else
        // rr_ptr is 1 after m0's burst, so m1 goes first
        expect_burst(1, 0, 1); expect_burst(0, 0, 1);
        expect_burst(1, 0, 1); expect_burst(0, 0, 1);
`endif
        issue(0, 2, 0);
        issue(1, 2, 0);
        wait_done("t2_timeout", 200);

        // m2 len=3 with slave gaps and a 2-cycle master stall
        slv_gap = 1'b1;
        expect_burst(2, 3, 4);
        issue(2, 1, 3);
        wait_rq("t3_wait_beat", 3, 100);
        m_rready[2] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("t3_srready_hold", s_rready, 0);
        end
        @(posedge clk);
        #2;
        m_rready[2] = 1'b1;
        wait_done("t3_timeout", 200);
        slv_gap = 1'b0;
        chk("t3_err", err_beat, 0);

        // early RLAST on the second beat of a len=3 burst
        slv_early = 1;
        expect_burst(1, 3, 2);
        issue(1, 1, 3);
        wait_done("t4_timeout", 100);
        chk("t4_err_set", err_beat, 1);
        chk("t4_idle", busy, 0);
        expect_burst(3, 0, 1);
        issue(3, 1, 0);
        wait_done("t4b_timeout", 100);
        chk("t4_err_sticky", err_beat, 1);

        // move rr_ptr away from 0, then reset in the middle of a long burst
        expect_burst(1, 0, 1);
        issue(1, 1, 0);
        wait_done("t5a_timeout", 100);
        slv_gap = 1'b1;
        expect_burst(2, 7, 8);
        issue(2, 1, 7);
        wait_rq("t5_wait_beats", 5, 200);
        chk("t5_busy_pre", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_s_arvalid", s_arvalid, 0);
        chk("t5_m_arready", m_arready, 0);
        chk("t5_m_rvalid",  m_rvalid, 0);
        chk("t5_s_rready",  s_rready, 0);
        chk("t5_busy",      busy, 0);
        chk("t5_err",       err_beat, 0);
        chk("t5_s_ar",      s_ar, 0);
        chk("t5_m_r",       m_r, 0);
        ar_q.delete();
        r_q.delete();
        m_arvalid = '0;
        m_ar      = '0;
        for (int i = 0; i < NUM_M; i++) req_left[i] = 0;
        slv_gap = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        // rr_ptr back at 0: m1 beats m3
        expect_burst(1, 0, 1);
        expect_burst(3, 0, 1);
        issue(1, 1, 0);
        issue(3, 1, 0);
        wait_done("t5b_timeout", 100);

        // m0 keeps asking, m1 and m2 two each
`ifdef AXI_RD_ARB_PRIO0_EN
        expect_burst(0, 0, 1); expect_burst(0, 0, 1); expect_burst(0, 0, 1);
        expect_burst(1, 0, 1); expect_burst(2, 0, 1);
        expect_burst(1, 0, 1); expect_burst(2, 0, 1);
`else
        expect_burst(0, 0, 1); expect_burst(1, 0, 1); expect_burst(2, 0, 1);
        expect_burst(0, 0, 1); expect_burst(1, 0, 1); expect_burst(2, 0, 1);
        expect_burst(0, 0, 1);
`endif
        issue(0, 3, 0);
        issue(1, 2, 0);
        issue(2, 2, 0);
        wait_done("t6_timeout", 300);
        chk("t6_err", err_beat, 0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
